// File: rtl/lvdc_mem_pkg.sv
// Shared definitions for the memory cycle sequencer: widths, requester
// indices, parameter defaults, sequencer states and the request payload.
package lvdc_mem_pkg;

  localparam int unsigned ADDR_W       = 9;
  localparam int unsigned NUM_REQ      = 3;
  localparam int unsigned ACC_CNT_W    = 4;
  localparam int unsigned STARVE_CNT_W = 3;

  // Requester positions inside the one-hot grant vector {P,D,I}
  localparam int unsigned REQ_I = 0;
  localparam int unsigned REQ_D = 1;
  localparam int unsigned REQ_P = 2;

  localparam int unsigned ACC_CYCLES_DEF   = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DECODE  = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  // Address and direction captured from the winning requester
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
  } req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Combinational requester arbiter: fixed priority P > D > I, with the
// instruction fetch forced to win once it has been starved long enough.
// Ports:
//   req    in  [2:0]  request levels {P,D,I}
//   starve in  1      starvation counter has reached its limit
//   sel_c  out [2:0]  one-hot winner {P,D,I}, zero when nothing requests
module mem_arbiter
  import lvdc_mem_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               starve,
  output logic [NUM_REQ-1:0] sel_c
);

  // Priority select with instruction-fetch starvation override
  always_comb begin
    sel_c = '0;
    if (starve && req[REQ_I]) begin
      sel_c[REQ_I] = 1'b1;
    end else if (req[REQ_P]) begin
      sel_c[REQ_P] = 1'b1;
    end else if (req[REQ_D]) begin
      sel_c[REQ_D] = 1'b1;
    end else if (req[REQ_I]) begin
      sel_c[REQ_I] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_cycle_sequencer.sv
// Memory cycle sequencer: arbitrates instruction, data and I/O requests and
// runs each granted access through LOAD, DECODE, ACCESS (ACC_CYCLES long)
// and RECOVER. A new grant may be taken directly out of RECOVER.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   IREQ/IADDR            instruction fetch request and address
//   DREQ/DADDR/DWR        data request, address and write flag
//   PREQ/PADDR/PWR        I/O request, address and write flag
//   A                     latched memory address
//   TA, DECEN, RD, WR     load strobe, decode enable, access strobes
//   GNT                   one-hot grant {P,D,I}
//   DONE, BUSY            completion pulse, not-idle indicator
module mem_cycle_sequencer
  import lvdc_mem_pkg::*;
#(
  parameter int unsigned ACC_CYCLES   = ACC_CYCLES_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IREQ,
  input  logic [ADDR_W-1:0] IADDR,
  input  logic              DREQ,
  input  logic [ADDR_W-1:0] DADDR,
  input  logic              DWR,
  input  logic              PREQ,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PWR,
  output logic [ADDR_W-1:0] A,
  output logic              TA,
  output logic              DECEN,
  output logic              RD,
  output logic              WR,
  output logic [NUM_REQ-1:0] GNT,
  output logic              DONE,
  output logic              BUSY
);

  state_t                  state_q, state_nxt;
  logic [ACC_CNT_W-1:0]    acc_cnt_q;
  logic [STARVE_CNT_W-1:0] starve_cnt_q;
  logic                    wr_flag_q;
  logic [NUM_REQ-1:0]      sel_c;
  logic                    starve_hit;
  logic                    grant;
  logic                    wr_nxt;
  req_t                    sel_req;

  assign starve_hit = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));

  mem_arbiter u_arb (
    .req    ({PREQ, DREQ, IREQ}),
    .starve (starve_hit),
    .sel_c  (sel_c)
  );

  // Next state, grant qualification and the winner's payload
  always_comb begin
    state_nxt = state_q;
    grant     = 1'b0;
    sel_req   = '{addr: IADDR, wr: 1'b0};
    if (sel_c[REQ_P]) begin
      sel_req = '{addr: PADDR, wr: PWR};
    end else if (sel_c[REQ_D]) begin
      sel_req = '{addr: DADDR, wr: DWR};
    end
    case (state_q)
      ST_IDLE: begin
        grant = |sel_c;
        if (grant) state_nxt = ST_LOAD;
      end
      ST_LOAD:   state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (acc_cnt_q == '0) state_nxt = ST_RECOVER;
      end
      ST_RECOVER: begin
        grant     = |sel_c;
        state_nxt = grant ? ST_LOAD : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    wr_nxt = grant ? sel_req.wr : wr_flag_q;
  end

  // State, latched access context and registered Moore outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      acc_cnt_q    <= '0;
      starve_cnt_q <= '0;
      wr_flag_q    <= 1'b0;
      A            <= '0;
      GNT          <= '0;
      TA           <= 1'b0;
      DECEN        <= 1'b0;
      RD           <= 1'b0;
      WR           <= 1'b0;
      DONE         <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (grant) begin
        A         <= sel_req.addr;
        GNT       <= sel_c;
        wr_flag_q <= sel_req.wr;
        // Count grants that passed over a waiting instruction fetch
        if (IREQ && !sel_c[REQ_I]) begin
          if (!starve_hit) starve_cnt_q <= starve_cnt_q + STARVE_CNT_W'(1);
        end else begin
          starve_cnt_q <= '0;
        end
      end else if (state_nxt == ST_IDLE) begin
        GNT <= '0;
      end
      // Down-counter loaded on DECODE so ACCESS spans ACC_CYCLES cycles
      if (state_q == ST_DECODE) begin
        acc_cnt_q <= ACC_CNT_W'(ACC_CYCLES - 1);
      end else if (state_q == ST_ACCESS && acc_cnt_q != '0) begin
        acc_cnt_q <= acc_cnt_q - ACC_CNT_W'(1);
      end
      TA    <= (state_nxt == ST_LOAD);
      DECEN <= (state_nxt == ST_DECODE) || (state_nxt == ST_ACCESS);
      RD    <= (state_nxt == ST_ACCESS) && !wr_nxt;
      WR    <= (state_nxt == ST_ACCESS) && wr_nxt;
      DONE  <= (state_nxt == ST_RECOVER);
      BUSY  <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Bench for mem_cycle_sequencer: directed scenarios plus a randomized run
// against a transaction-level timeline model.
module tb_mem_cycle_sequencer;

  localparam int ACC = 4;
  localparam int LIM = 3;
  localparam int LEN = ACC + 3;

  logic       CLK = 1'b0;
  logic       RESET, IREQ, DREQ, DWR, PREQ, PWR;
  logic [8:0] IADDR, DADDR, PADDR;
  logic [8:0] A, A1;
  logic       TA, DECEN, RD, WR, DONE, BUSY;
  logic       TA1, DECEN1, RD1, WR1, DONE1, BUSY1;
  logic [2:0] GNT, GNT1;
  wire [17:0] obs  = {A, TA, DECEN, RD, WR, GNT, DONE, BUSY};
  wire [17:0] obs1 = {A1, TA1, DECEN1, RD1, WR1, GNT1, DONE1, BUSY1};

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mem_cycle_sequencer dut (
    .CLK(CLK), .RESET(RESET), .IREQ(IREQ), .IADDR(IADDR),
    .DREQ(DREQ), .DADDR(DADDR), .DWR(DWR),
    .PREQ(PREQ), .PADDR(PADDR), .PWR(PWR),
    .A(A), .TA(TA), .DECEN(DECEN), .RD(RD), .WR(WR),
    .GNT(GNT), .DONE(DONE), .BUSY(BUSY)
  );

  mem_cycle_sequencer #(.ACC_CYCLES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .IREQ(IREQ), .IADDR(IADDR),
    .DREQ(DREQ), .DADDR(DADDR), .DWR(DWR),
    .PREQ(PREQ), .PADDR(PADDR), .PWR(PWR),
    .A(A1), .TA(TA1), .DECEN(DECEN1), .RD(RD1), .WR(WR1),
    .GNT(GNT1), .DONE(DONE1), .BUSY(BUSY1)
  );

  // Expected outputs k cycles after a grant edge (k = 0 means idle)
  function automatic logic [17:0] expect_at(int k, int acc, logic w, int g,
                                            logic [8:0] a);
    logic       in_acc, ta, decen, done, busy;
    logic [2:0] gnt;
    in_acc = (k >= 3) && (k <= acc + 2);
    ta     = (k == 1);
    decen  = (k >= 2) && (k <= acc + 2);
    done   = (k == acc + 3);
    busy   = (k != 0);
    gnt    = busy ? 3'(1 << g) : 3'b000;
    return {a, ta, decen, in_acc && !w, in_acc && w, gnt, done, busy};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; IREQ = 0; DREQ = 0; PREQ = 0; DWR = 0; PWR = 0;
    IADDR = '0; DADDR = '0; PADDR = '0;
    cyc(); cyc();
    n_vec++;
    if (obs !== 18'h0) begin
      n_err++; $display("FAIL reset_state got %h want %h", obs, 18'h0);
    end
    n_vec++;
    if (obs1 !== 18'h0) begin
      n_err++; $display("FAIL reset_state_acc1 got %h want %h", obs1, 18'h0);
    end
    RESET = 1'b0;
    cyc();
    n_vec++;
    if (obs !== 18'h0) begin
      n_err++; $display("FAIL idle_after_reset got %h want %h", obs, 18'h0);
    end
  endtask

  task automatic test_fetch();
    logic [17:0] exp;
    IREQ = 1'b1; IADDR = 9'h0A5;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      exp = expect_at((c <= LEN) ? c : 0, ACC, 1'b0, 0, 9'h0A5);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL fetch cyc %0d got %h want %h", c, obs, exp);
      end
      if (c == LEN) IREQ = 1'b0;
    end
  endtask

  task automatic test_priority();
    int         order [3] = '{2, 1, 0};
    logic [8:0] addr  [3] = '{9'h1C3, 9'h04E, 9'h111};
    logic       wrs   [3] = '{1'b1, 1'b0, 1'b0};
    logic [17:0] exp;
    int t, k;
    PREQ = 1; PADDR = 9'h1C3; PWR = 1;
    DREQ = 1; DADDR = 9'h04E; DWR = 0;
    IREQ = 1; IADDR = 9'h111;
    for (int c = 1; c <= 22; c++) begin
      cyc();
      t = (c - 1) / LEN;
      k = (c - 1) % LEN + 1;
      if (t > 2) exp = expect_at(0, ACC, 1'b0, 0, 9'h111);
      else       exp = expect_at(k, ACC, wrs[t], order[t], addr[t]);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL priority cyc %0d got %h want %h", c, obs, exp);
      end
      if (t <= 2 && k == LEN) begin
        if (order[t] == 2) PREQ = 0;
        if (order[t] == 1) DREQ = 0;
        if (order[t] == 0) IREQ = 0;
      end
    end
  endtask

  task automatic test_starvation();
    logic [17:0] exp;
    int t, k, g;
    DREQ = 1; DWR = 1; DADDR = 9'h0F0;
    IREQ = 1; IADDR = 9'h10F;
    for (int c = 1; c <= 5 * LEN; c++) begin
      cyc();
      t = (c - 1) / LEN;
      k = (c - 1) % LEN + 1;
      g = (t == LIM) ? 0 : 1;
      exp = expect_at(k, ACC, g == 1, g, (g == 1) ? 9'h0F0 : 9'h10F);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL starvation cyc %0d got %h want %h", c, obs, exp);
      end
      if (k == LEN && g == 0) IREQ = 0;
    end
    DREQ = 0;
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp;
    IREQ = 1; IADDR = 9'h17E;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      exp = expect_at(c, ACC, 1'b0, 0, 9'h17E);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL reset_mid cyc %0d got %h want %h", c, obs, exp);
      end
    end
    RESET = 1; IREQ = 0;
    cyc();
    RESET = 0;
    for (int c = 7; c <= 10; c++) begin
      n_vec++;
      if (obs !== 18'h0) begin
        n_err++; $display("FAIL reset_mid cyc %0d got %h want %h", c, obs, 18'h0);
      end
      cyc();
    end
  endtask

  task automatic test_drop();
    logic [17:0] exp;
    DREQ = 1; DADDR = 9'h0C9; DWR = 0;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      exp = expect_at((c <= LEN) ? c : 0, ACC, 1'b0, 1, 9'h0C9);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL drop cyc %0d got %h want %h", c, obs, exp);
      end
      if (c == 1) DREQ = 0;
    end
  endtask

  task automatic test_acc1();
    logic [17:0] exp;
    RESET = 1; cyc(); RESET = 0;
    IREQ = 1; IADDR = 9'h02B;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      exp = expect_at((c <= 4) ? c : 0, 1, 1'b0, 0, 9'h02B);
      n_vec++;
      if (obs1 !== exp) begin
        n_err++; $display("FAIL acc1 cyc %0d got %h want %h", c, obs1, exp);
      end
      if (c == 4) IREQ = 0;
    end
    RESET = 1; cyc(); RESET = 0;
  endtask

  task automatic test_random(int n);
    logic       rq [3];
    logic [8:0] ra [3];
    logic       rw [3];
    logic       rst;
    logic [8:0] a;
    logic       w;
    logic [17:0] exp;
    int k, g, ng, starve;
    RESET = 1; IREQ = 0; DREQ = 0; PREQ = 0;
    cyc();
    k = 0; g = 0; a = '0; w = 0; starve = 0;
    for (int i = 0; i < 3; i++) begin rq[i] = 0; ra[i] = '0; rw[i] = 0; end
    for (int i = 0; i < n; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      RESET = rst;
      IREQ = rq[0]; IADDR = ra[0];
      DREQ = rq[1]; DADDR = ra[1]; DWR = rw[1];
      PREQ = rq[2]; PADDR = ra[2]; PWR = rw[2];
      @(posedge CLK);
      if (rst) begin
        k = 0; a = '0; starve = 0;
      end else if (k == 0 || k == LEN) begin
        if (rq[0] || rq[1] || rq[2]) begin
          if (starve == LIM && rq[0]) ng = 0;
          else if (rq[2])             ng = 2;
          else if (rq[1])             ng = 1;
          else                        ng = 0;
          if (rq[0] && ng != 0) starve = (starve < LIM) ? starve + 1 : LIM;
          else                  starve = 0;
          g = ng; a = ra[ng]; w = (ng == 0) ? 1'b0 : rw[ng]; k = 1;
        end else begin
          k = 0;
        end
      end else begin
        k++;
      end
      #1;
      exp = expect_at(k, ACC, w, g, a);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL random cyc %0d got %h want %h", i, obs, exp);
      end
      // Requesters: release on DONE, wiggle the granted address, raise new
      if (k == LEN) rq[g] = 0;
      if (k >= 1 && k < LEN && $urandom_range(0, 3) == 0) ra[g] = 9'($urandom);
      for (int r = 0; r < 3; r++) begin
        if (!rq[r] && $urandom_range(0, 3) == 0) begin
          rq[r] = 1;
          ra[r] = 9'($urandom);
          rw[r] = (r == 0) ? 1'b0 : 1'($urandom);
        end
      end
    end
    RESET = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starvation();
    test_reset_mid();
    test_drop();
    test_acc1();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
